// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared types and helpers for the parametrised SPI master.
//   - state_e    : transfer FSM states (IDLE -> SETUP -> XFER -> HOLD -> IDLE)
//   - spi_mode_t : CPOL/CPHA pair latched when a frame is accepted
//   - idx_w()    : index width for N items, never less than one bit
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Width of an index selecting one of n items. A single item still gets a
  // one-bit select so port widths never collapse to zero.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
//   Half-period tick generator for the SPI master. While enabled, tick is high
//   for one clk cycle every (div+1) cycles; disabling clears the counter so the
//   first tick after enable arrives exactly div+1 cycles later.
//   Ports:
//     clk, rst  - system clock, asynchronous active-low reset
//     en        - count enable (high while a transfer is in progress)
//     div       - half-period minus one, in clk cycles
//     tick      - one-cycle half-period strobe
// -----------------------------------------------------------------------------
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Comparing against div (instead of counting up to div+1) lets the maximum
  // divider run without needing an extra counter bit.
  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != div)) cnt_d = cnt_q + DIV_W'(1);
  end

  assign tick = en && (cnt_q == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
//   Parametrised SPI master with run-time CPOL/CPHA and SCK divider.
//   A frame is accepted when load_data is high on an edge while idle; data,
//   cs_sel, cpol, cpha and clk_div are captured at that edge. The transfer is
//   SETUP (H cycles), 2*DATA_W SCK edges spaced H cycles apart, then HOLD
//   (H cycles), where H = clk_div+1. received_data and a one-cycle rx_valid
//   are produced in the cycle cs deasserts and busy falls.
//   Ports:
//     clk, rst       - system clock, asynchronous active-low reset
//     data           - TX frame, sampled on accept
//     load_data      - start request, honoured only while idle
//     cs_sel         - chip-select index; out-of-range keeps all cs high
//     cpol, cpha     - SPI mode
//     clk_div        - SCK half-period minus one
//     miso / mosi    - serial data in / out
//     sck            - SPI clock
//     cs             - active-low chip selects
//     busy           - transfer in progress
//     received_data  - last completed RX frame
//     rx_valid       - one-cycle strobe when received_data updates
// -----------------------------------------------------------------------------
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_CS    = 1,
  parameter int DIV_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         data,
  input  logic                      load_data,
  input  logic [idx_w(NUM_CS)-1:0]  cs_sel,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic [DIV_W-1:0]          clk_div,
  input  logic                      miso,
  output logic                      mosi,
  output logic                      sck,
  output logic [NUM_CS-1:0]         cs,
  output logic                      busy,
  output logic [DATA_W-1:0]         received_data,
  output logic                      rx_valid
);

  localparam int              BIT_W    = idx_w(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              trail_q, trail_d;   // next SCK edge is a trailing edge
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              rxv_q, rxv_d;
  logic [NUM_CS-1:0] cs_q, cs_d;

  logic clk_en;
  logic tick;

  assign clk_en = (state_q != IDLE);

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (clk_en),
    .div  (div_q),
    .tick (tick)
  );

  // Bit-order helpers: the bit presented next, the register after it leaves,
  // and the receive register after a new bit arrives.
  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                 input logic              b);
    return MSB_FIRST ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
  endfunction

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case
    // below can leave a signal unassigned and infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    bit_d   = bit_q;
    trail_d = trail_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    cs_d    = cs_q;
    rxv_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        sck_d  = cpol;
        mosi_d = 1'b0;
        cs_d   = '1;
        busy_d = 1'b0;
        if (load_data) begin
          state_d = SETUP;
          mode_d  = '{cpol: cpol, cpha: cpha};
          div_d   = clk_div;
          busy_d  = 1'b1;
          bit_d   = '0;
          trail_d = 1'b0;
          rx_d    = '0;
          for (int i = 0; i < NUM_CS; i++) cs_d[i] = (int'(cs_sel) != i);
          if (cpha) begin
            tx_d = data;
          end else begin
            // CPHA=0 needs the first bit on the wire before the leading edge.
            mosi_d = first_bit(data);
            tx_d   = shift_out(data);
          end
        end
      end

      SETUP: begin
        if (tick) state_d = XFER;
      end

      XFER: begin
        if (tick) begin
          sck_d   = ~sck_q;
          trail_d = ~trail_q;
          if (!trail_q) begin
            if (mode_q.cpha) begin
              mosi_d = first_bit(tx_q);
              tx_d   = shift_out(tx_q);
            end else begin
              rx_d = shift_in(rx_q, miso);
            end
          end else begin
            if (mode_q.cpha) begin
              rx_d = shift_in(rx_q, miso);
            end else if (bit_q != LAST_BIT) begin
              mosi_d = first_bit(tx_q);
              tx_d   = shift_out(tx_q);
            end
            if (bit_q == LAST_BIT) state_d = HOLD;
            else                   bit_d   = bit_q + BIT_W'(1);
          end
        end
      end

      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          sck_d   = mode_q.cpol;
          mosi_d  = 1'b0;
          cs_d    = '1;
          busy_d  = 1'b0;
          rdata_d = rx_q;
          rxv_d   = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // sees the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      div_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      bit_q   <= '0;
      trail_q <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= '1;
      rxv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      bit_q   <= bit_d;
      trail_q <= trail_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      rxv_q   <= rxv_d;
    end
  end

  assign mosi          = mosi_q;
  assign sck           = sck_q;
  assign cs            = cs_q;
  assign busy          = busy_q;
  assign received_data = rdata_q;
  assign rx_valid      = rxv_q;

endmodule

// File: tb/tb_spi_master_param.sv
// -----------------------------------------------------------------------------
// tb_spi_master_param
//   Two DUTs: u_msb (8-bit, 3 chip selects, MSB first) with a mode-aware SPI
//   slave on cs[0] or a mosi->miso loopback, and u_lsb (8-bit, 1 chip select,
//   LSB first) in loopback. Expected RX frames are queued at issue time and
//   popped by per-DUT monitors whenever rx_valid is seen.
// -----------------------------------------------------------------------------
module tb_spi_master_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u_msb signals
  logic [7:0] data_a;
  logic       load_a;
  logic [1:0] cs_sel_a;
  logic       cpol_a, cpha_a;
  logic [7:0] clk_div_a;
  logic       miso_a, mosi_a, sck_a, busy_a, rxv_a;
  logic [2:0] cs_a;
  logic [7:0] rdata_a;

  // u_lsb signals
  logic [7:0] data_b;
  logic       load_b;
  logic [0:0] cs_sel_b;
  logic       cpol_b, cpha_b;
  logic [7:0] clk_div_b;
  logic       miso_b, mosi_b, sck_b, busy_b, rxv_b;
  logic [0:0] cs_b;
  logic [7:0] rdata_b;

  // Slave model state
  logic       loopback;
  logic       slv_miso;
  logic       slv_cpol, slv_cpha;
  logic [7:0] slv_tx, slv_rx;
  int         slv_bit, slv_edges;

  assign miso_a = loopback ? mosi_a : slv_miso;
  assign miso_b = mosi_b;

  spi_master_param #(.DATA_W(8), .NUM_CS(3), .DIV_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .data(data_a), .load_data(load_a), .cs_sel(cs_sel_a),
    .cpol(cpol_a), .cpha(cpha_a), .clk_div(clk_div_a), .miso(miso_a),
    .mosi(mosi_a), .sck(sck_a), .cs(cs_a), .busy(busy_a),
    .received_data(rdata_a), .rx_valid(rxv_a)
  );

  spi_master_param #(.DATA_W(8), .NUM_CS(1), .DIV_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data(data_b), .load_data(load_b), .cs_sel(cs_sel_b),
    .cpol(cpol_b), .cpha(cpha_b), .clk_div(clk_div_b), .miso(miso_b),
    .mosi(mosi_b), .sck(sck_b), .cs(cs_b), .busy(busy_b),
    .received_data(rdata_b), .rx_valid(rxv_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  int rx_seen_a = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- SPI slave on u_msb cs[0], MSB first ----------------
  always @(negedge cs_a[0]) begin
    slv_bit   = 0;
    slv_edges = 0;
    slv_rx    = 8'h00;
    if (!slv_cpha) begin
      slv_miso = slv_tx[7];
      slv_bit  = 1;
    end
  end

  always @(sck_a) begin : slv_edge
    logic lead, samp;
    if (cs_a[0] === 1'b0) begin
      lead = (sck_a != slv_cpol);
      samp = slv_cpha ? !lead : lead;
      slv_edges++;
      if (samp) begin
        slv_rx = {slv_rx[6:0], mosi_a};
      end else if (slv_bit < 8) begin
        slv_miso = slv_tx[7 - slv_bit];
        slv_bit++;
      end
    end
  end

  // ---------------- Scoreboard monitors ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 && rxv_a === 1'b1) begin
      rx_seen_a++;
      if (exp_q_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL msb unexpected rx_valid: received_data=%0h with no frame pending", rdata_a);
      end else begin
        check("msb received_data", rdata_a, exp_q_a.pop_front());
        check("msb busy low at rx_valid", busy_a, 1'b0);
        check("msb cs high at rx_valid", cs_a, 3'b111);
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && rxv_b === 1'b1) begin
      if (exp_q_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL lsb unexpected rx_valid: received_data=%0h with no frame pending", rdata_b);
      end else begin
        check("lsb received_data", rdata_b, exp_q_b.pop_front());
      end
    end
  end

  // ---------------- Frame driver for u_msb ----------------
  task automatic do_frame(input string nm, input logic [7:0] d, input logic pol,
                          input logic pha, input logic [7:0] div, input logic [1:0] sel,
                          input logic lb, input logic [7:0] stx, input logic [7:0] exp_rx,
                          input logic [2:0] exp_cs, input int mid_at);
    int h, busy_cnt, cs_cnt, edges, run, run_min, run_max, guard;
    logic prev;
    h = int'(div) + 1;
    loopback = lb;
    slv_tx = stx; slv_cpol = pol; slv_cpha = pha;
    cpol_a = pol; cpha_a = pha; clk_div_a = div; cs_sel_a = sel;
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("%s idle sck", nm), sck_a, pol);
    check($sformatf("%s idle cs", nm), cs_a, 3'b111);
    data_a = d;
    load_a = 1'b1;
    exp_q_a.push_back(exp_rx);
    @(posedge clk);
    #1;
    load_a = 1'b0;
    check($sformatf("%s cs during", nm), cs_a, exp_cs);
    if (!pha) check($sformatf("%s first mosi", nm), mosi_a, d[7]);
    busy_cnt = 0; cs_cnt = 0; edges = 0; run = 0;
    run_min = 1 << 30; run_max = 0; guard = 0; prev = pol;
    while (busy_a === 1'b1 && guard < 5000) begin
      busy_cnt++;
      if (cs_a !== 3'b111) cs_cnt++;
      if (sck_a !== prev) begin
        edges++;
        if (edges > 1) begin
          if (run < run_min) run_min = run;
          if (run > run_max) run_max = run;
        end
        run  = 1;
        prev = sck_a;
      end else begin
        run++;
      end
      load_a = (guard == mid_at);
      if (guard == mid_at) data_a = 8'hFF;
      @(posedge clk);
      #1;
      guard++;
    end
    load_a = 1'b0;
    check($sformatf("%s busy cycles", nm), busy_cnt, 18 * h);
    check($sformatf("%s cs low cycles", nm), cs_cnt, (exp_cs == 3'b111) ? 0 : 18 * h);
    check($sformatf("%s sck edges", nm), edges, 16);
    check($sformatf("%s sck min half period", nm), run_min, h);
    check($sformatf("%s sck max half period", nm), run_max, h);
    check($sformatf("%s sck back to idle", nm), sck_a, pol);
    if (sel == 2'd0) begin
      check($sformatf("%s slave saw mosi", nm), slv_rx, d);
      check($sformatf("%s slave edge count", nm), slv_edges, 16);
    end
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("%s no restart", nm), busy_a, 1'b0);
  endtask

  // ---------------- Frame driver for u_lsb ----------------
  task automatic do_frame_b(input logic [7:0] d);
    int busy_cnt, guard;
    data_b = d;
    load_b = 1'b1;
    exp_q_b.push_back(d);
    @(posedge clk);
    #1;
    load_b = 1'b0;
    check("lsb first mosi", mosi_b, d[0]);
    check("lsb cs asserted", cs_b, 1'b0);
    busy_cnt = 0; guard = 0;
    while (busy_b === 1'b1 && guard < 5000) begin
      busy_cnt++;
      @(posedge clk);
      #1;
      guard++;
    end
    check("lsb busy cycles", busy_cnt, 18);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, gap, seen0;
    rst = 1'b0;
    data_a = '0; load_a = 1'b0; cs_sel_a = '0; cpol_a = 1'b0; cpha_a = 1'b0; clk_div_a = '0;
    data_b = '0; load_b = 1'b0; cs_sel_b = '0; cpol_b = 1'b0; cpha_b = 1'b0; clk_div_b = '0;
    loopback = 1'b1; slv_miso = 1'b0; slv_cpol = 1'b0; slv_cpha = 1'b0;
    slv_tx = '0; slv_rx = '0; slv_bit = 0; slv_edges = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset sck", sck_a, 1'b0);
    check("reset mosi", mosi_a, 1'b0);
    check("reset cs", cs_a, 3'b111);
    check("reset busy", busy_a, 1'b0);
    check("reset received_data", rdata_a, 8'h00);
    check("reset rx_valid", rxv_a, 1'b0);
    rst = 1'b1;

    //       name    data   pol   pha   div    sel   lb    slave  exp    cs      mid
    do_frame("m0",   8'h1F, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1, 8'h00, 8'h1F, 3'b110, -1);
    do_frame("m3",   8'h5C, 1'b1, 1'b1, 8'd1, 2'd0, 1'b0, 8'hA5, 8'hA5, 3'b110, -1);
    do_frame("div3", 8'h96, 1'b0, 1'b1, 8'd3, 2'd0, 1'b0, 8'h3C, 8'h3C, 3'b110, -1);
    do_frame("mid",  8'hA0, 1'b1, 1'b0, 8'd0, 2'd0, 1'b0, 8'h81, 8'h81, 3'b110, 6);
    do_frame("cs2",  8'h6B, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1, 8'h00, 8'h6B, 3'b011, -1);
    do_frame("cs3",  8'hC4, 1'b0, 1'b0, 8'd0, 2'd3, 1'b1, 8'h00, 8'hC4, 3'b111, -1);

    // Back-to-back frames with load_data held high
    loopback = 1'b1; cpol_a = 1'b0; cpha_a = 1'b0; clk_div_a = 8'd0; cs_sel_a = 2'd0;
    slv_cpol = 1'b0; slv_cpha = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    seen0 = rx_seen_a;
    data_a = 8'h31; load_a = 1'b1;
    exp_q_a.push_back(8'h31);
    @(posedge clk);
    #1;
    check("b2b first accept", busy_a, 1'b1);
    data_a = 8'h5C;
    exp_q_a.push_back(8'h5C);
    guard = 0;
    while (busy_a === 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("b2b cs high between frames", cs_a, 3'b111);
    gap = 0;
    while (busy_a !== 1'b1 && guard < 200) begin
      gap++;
      @(posedge clk);
      #1;
      guard++;
    end
    check("b2b idle gap", gap, 1);
    load_a = 1'b0;
    while (busy_a === 1'b1 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("b2b rx_valid pulses", rx_seen_a - seen0, 2);

    // Reset in the middle of a frame on both DUTs
    data_a = 8'hC3; data_b = 8'h5A;
    load_a = 1'b1; load_b = 1'b1;
    @(posedge clk);
    #1;
    load_a = 1'b0; load_b = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort msb sck", sck_a, 1'b0);
    check("abort msb mosi", mosi_a, 1'b0);
    check("abort msb cs", cs_a, 3'b111);
    check("abort msb busy", busy_a, 1'b0);
    check("abort msb received_data", rdata_a, 8'h00);
    check("abort msb rx_valid", rxv_a, 1'b0);
    check("abort lsb cs", cs_b, 1'b1);
    check("abort lsb busy", busy_b, 1'b0);
    check("abort lsb mosi", mosi_b, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post-reset msb idle", busy_a, 1'b0);

    do_frame("after rst", 8'hE7, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1, 8'h00, 8'hE7, 3'b110, -1);
    do_frame_b(8'h01);
    do_frame_b(8'h2D);

    repeat (5) @(posedge clk);
    #1;
    check("msb frames outstanding", exp_q_a.size(), 0);
    check("lsb frames outstanding", exp_q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
